bcd_bin_converter: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 3-digit multiplexed 7-segment display driver and supplies its packed BCD digits.
- Uses a start/busy/done handshake.
- Holds the last result stable on the output so the display never shows partial values.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_bin_converter_if.sv | 18 +
 rtl/bcd_add3.sv | 10 +
 rtl/bcd_bin_converter.sv | 92 +++++++++
 tb/tb_bcd_bin_converter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int BCD_NIBBLE_W = 4;

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_bin_converter_if.sv
// Start/busy/done handshake plus data between the converter and its user.
interface bcd_bin_converter_if
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) ();

    logic                           start;
    logic [WIDTH-1:0]               bin_in;
    logic                           busy;
    logic                           done;
    logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_out;

    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the
// shift so that the doubled value carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    assign nibble_o = (nibble_i >= 4'd5) ? nibble_i + 4'd3 : nibble_i;

endmodule

// File: rtl/bcd_bin_converter.sv
// Binary-to-BCD converter, one double-dabble step per clock.
// bcd_out is a separate holding register so the downstream display only
// ever sees complete results.
//
//   state | meaning
//   IDLE  | waiting for start; bcd_out holds last result
//   SHIFT | add-3 then shift, once per edge, WIDTH times
module bcd_bin_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_bin_converter_if.slave  bus
);

    localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int SCR_W = BCD_W + WIDTH;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    if (pow10(DIGITS) <= MAX_BIN) begin : g_range_check
        $error("bcd_bin_converter: DIGITS too small to represent 2**WIDTH-1");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   adj_bcd;

    // Per-digit add-3 correction on the BCD part of the scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble_i (scratch_q[WIDTH + g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .nibble_o (adj_bcd[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
        );
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    // Next-state: capture on start, then correct-and-shift until the count expires.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    scratch_d = {{BCD_W{1'b0}}, bus.bin_in};
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj_bcd, scratch_q[WIDTH-1:0]} << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scratch_d[SCR_W-1 -: BCD_W];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_bin_converter.sv
// Self-checking bench for bcd_bin_converter against a decimal-arithmetic model.
module tb_bcd_bin_converter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_bin_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_bin_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [BCD_W-1:0] prev_bcd;

    function automatic logic [BCD_W-1:0] ref_bcd(input int v);
        logic [BCD_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic nibbles_legal(input logic [BCD_W-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (b[d*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic convert(input int v);
        int n;
        bit seen;
        logic [BCD_W-1:0] e;
        e = ref_bcd(v);
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(v);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bin_in = WIDTH'($urandom);
        chk("busy_after_accept", bus.busy, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1'b1;
            else chk("bcd_stable_while_busy", bus.bcd_out, prev_bcd);
        end
        chk("done_latency", n, WIDTH);
        chk("bcd_value", bus.bcd_out, e);
        chk("busy_in_done_cycle", bus.busy, 0);
        chk("nibbles_legal", nibbles_legal(bus.bcd_out), 1);
        @(negedge clk);
        chk("done_width", bus.done, 0);
        chk("bcd_hold", bus.bcd_out, e);
        prev_bcd = e;
    endtask

    initial begin
        int ndone;
        logic [BCD_W-1:0] val;
        logic [BCD_W-1:0] last;
        logic [BCD_W-1:0] chg[$];
        int dt[2];
        int nd;

        bus.start  = 1'b0;
        bus.bin_in = '0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_bcd", bus.bcd_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        prev_bcd = '0;

        // Directed values including zero and the maximum input.
        convert(0);
        convert(255);
        convert(99);
        convert(100);

        // Second start mid-conversion must be ignored.
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(37);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.bin_in = WIDTH'(200);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        val = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                val = bus.bcd_out;
            end
        end
        chk("ignored_start_done_count", ndone, 1);
        chk("ignored_start_value", val, ref_bcd(37));
        prev_bcd = ref_bcd(37);

        // Start held high: back-to-back conversions every WIDTH+1 cycles.
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(128);
        last = prev_bcd;
        nd = 0;
        dt[0] = 0;
        dt[1] = 0;
        for (int i = 1; i <= 30 && nd < 2; i++) begin
            @(negedge clk);
            if (i == 1) bus.bin_in = WIDTH'(9);
            if (bus.bcd_out !== last) begin
                chg.push_back(bus.bcd_out);
                last = bus.bcd_out;
            end
            if (bus.done) begin
                dt[nd] = i;
                nd++;
            end
        end
        bus.start = 1'b0;
        chk("b2b_done_count", nd, 2);
        chk("b2b_period", dt[1] - dt[0], WIDTH + 1);
        chk("b2b_change_count", chg.size(), 2);
        chk("b2b_first", (chg.size() > 0) ? chg[0] : 'x, ref_bcd(128));
        chk("b2b_second", (chg.size() > 1) ? chg[1] : 'x, ref_bcd(9));
        @(negedge clk);
        chk("b2b_idle", bus.busy, 0);
        prev_bcd = ref_bcd(9);

        // Reset on the fifth shift edge discards the conversion.
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(255);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_done", bus.done, 0);
        chk("midreset_bcd", bus.bcd_out, 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("midreset_no_done", ndone, 0);
        prev_bcd = '0;
        convert(42);

        // Exhaustive sweep.
        for (int v = 0; v < (1 << WIDTH); v++) begin
            convert(v);
        end

        // Random values with random idle gaps.
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            convert(int'($urandom_range(0, (1 << WIDTH) - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
